// File: rtl/clk_strobe_seq_if.sv
// Handshake and capture-bank bus of the strobe sequencer.
// The master (requester) drives start/byte_in; the slave (sequencer) drives the rest.
interface clk_strobe_seq_if;
  logic       start;
  logic [7:0] byte_in;
  logic       ready;
  logic       data_out;
  logic [7:0] strobe;
  logic       busy;
  logic       done;

  modport master (
    output start, byte_in,
    input  ready, data_out, strobe, busy, done
  );

  modport slave (
    input  start, byte_in,
    output ready, data_out, strobe, busy, done
  );
endinterface

// File: rtl/clk_strobe_seq.sv
// Serialises a byte into an 8-flop capture bank: one shared data line, one clock strobe per bit.
// Optional macro STROBE_HOLD_EN adds a one-cycle HOLD after every strobe pulse.
module clk_strobe_seq #(
  parameter int SETUP_CYCLES = 1
) (
  input logic            ff_clock,
  input logic            rst,
  clk_strobe_seq_if.slave bus
);

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
`ifdef STROBE_HOLD_EN
    HOLD,
`endif
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] strobe_q, strobe_d;
  logic       data_out_q, data_out_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic       advance;

  // Bit i of the byte is clocked into bank bit i, which listens on strobe[7-i].
  function automatic logic [7:0] strobe_onehot(input logic [2:0] i);
    strobe_onehot = 8'h80 >> i;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    strobe_d   = strobe_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ready_d    = ready_q;
    advance    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          byte_d     = bus.byte_in;
          idx_d      = 3'd0;
          data_out_d = bus.byte_in[0];
          cnt_d      = SETUP_LAST;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          strobe_d = strobe_onehot(idx_q);
          state_d  = STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        strobe_d = 8'h00;
`ifdef STROBE_HOLD_EN
        state_d  = HOLD;
`else
        advance  = 1'b1;
`endif
      end
`ifdef STROBE_HOLD_EN
      HOLD: begin
        advance = 1'b1;
      end
`endif
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        strobe_d = 8'h00;
        busy_d   = 1'b0;
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
    endcase

    // Next bit's data changes on the same edge the strobe falls (or leaves HOLD).
    if (advance) begin
      if (idx_q == 3'd7) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end else begin
        idx_d      = idx_q + 3'd1;
        data_out_d = byte_q[idx_q + 3'd1];
        cnt_d      = SETUP_LAST;
        state_d    = SETUP;
      end
    end
  end

  always_ff @(posedge ff_clock or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= 3'd0;
      byte_q     <= 8'h00;
      strobe_q   <= 8'h00;
      data_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      strobe_q   <= strobe_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.strobe   = strobe_q;
  assign bus.data_out = data_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ready    = ready_q;

endmodule

// File: tb/tb_clk_strobe_seq.sv
// Scoreboard bench for clk_strobe_seq: two instances (SETUP_CYCLES=1 and 3) feeding model capture banks.
module tb_clk_strobe_seq;

`ifdef STROBE_HOLD_EN
  localparam int HOLD_X = 1;
`else
  localparam int HOLD_X = 0;
`endif
  localparam int SU0 = 1;
  localparam int SU1 = 3;

  logic ff_clock = 1'b0;
  logic rst      = 1'b1;
  always #5 ff_clock = ~ff_clock;

  logic       start_v [2] = '{1'b0, 1'b0};
  logic [7:0] byte_v  [2] = '{8'h00, 8'h00};

  clk_strobe_seq_if bus0();
  clk_strobe_seq_if bus1();

  assign bus0.start   = start_v[0];
  assign bus0.byte_in = byte_v[0];
  assign bus1.start   = start_v[1];
  assign bus1.byte_in = byte_v[1];

  clk_strobe_seq #(.SETUP_CYCLES(SU0)) dut0 (.ff_clock(ff_clock), .rst(rst), .bus(bus0));
  clk_strobe_seq #(.SETUP_CYCLES(SU1)) dut1 (.ff_clock(ff_clock), .rst(rst), .bus(bus1));

  logic [7:0] strb [2];
  logic       dout [2];
  logic       dn   [2];
  logic       rdy  [2];
  logic       bsy  [2];
  assign strb[0] = bus0.strobe;   assign strb[1] = bus1.strobe;
  assign dout[0] = bus0.data_out; assign dout[1] = bus1.data_out;
  assign dn[0]   = bus0.done;     assign dn[1]   = bus1.done;
  assign rdy[0]  = bus0.ready;    assign rdy[1]  = bus1.ready;
  assign bsy[0]  = bus0.busy;     assign bsy[1]  = bus1.busy;

  typedef struct { int cyc; logic [7:0] strb; logic dbit; } sx_t;
  typedef struct { int cyc; logic [7:0] cap; } dx_t;

  sx_t sq [2][$];
  dx_t dq [2][$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] cap     [2] = '{8'h00, 8'h00};
  logic       prev_d  [2] = '{1'b0, 1'b0};
  logic       prev_dn [2] = '{1'b0, 1'b0};
  int         stab    [2] = '{0, 0};
  sx_t        e;
  dx_t        f;

  function automatic int su(input int k);
    return (k == 0) ? SU0 : SU1;
  endfunction

  function automatic int per(input int k);
    return su(k) + 1 + HOLD_X;
  endfunction

  always @(posedge ff_clock) cyc++;

  // Monitor: model capture bank, scoreboard pops, one-hot and done-width checks.
  always @(negedge ff_clock) begin
    for (int k = 0; k < 2; k++) begin
      total++;
      if ($countones(strb[k]) > 1) begin
        bad++;
        $display("FAIL onehot dut%0d cyc=%0d strobe=%h want zero or one-hot", k, cyc, strb[k]);
      end
      if (dout[k] === prev_d[k]) stab[k]++;
      else stab[k] = 1;
      prev_d[k] = dout[k];
      if (strb[k] != 8'h00) begin
        for (int b = 0; b < 8; b++) if (strb[k][b]) cap[k][7-b] = dout[k];
        total++;
        if (sq[k].size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe dut%0d cyc=%0d strobe=%h want none", k, cyc, strb[k]);
        end else begin
          e = sq[k].pop_front();
          if (cyc !== e.cyc || strb[k] !== e.strb || dout[k] !== e.dbit) begin
            bad++;
            $display("FAIL strobe dut%0d got cyc=%0d strobe=%h data=%b want cyc=%0d strobe=%h data=%b",
                     k, cyc, strb[k], dout[k], e.cyc, e.strb, e.dbit);
          end
          total++;
          if (stab[k] < su(k) + 1) begin
            bad++;
            $display("FAIL setup_stable dut%0d cyc=%0d got=%0d stable samples want>=%0d", k, cyc, stab[k], su(k) + 1);
          end
        end
      end
      if (dn[k] === 1'b1) begin
        total++;
        if (prev_dn[k] === 1'b1) begin
          bad++;
          $display("FAIL done_width dut%0d cyc=%0d done high two cycles want single pulse", k, cyc);
        end
        total++;
        if (dq[k].size() == 0) begin
          bad++;
          $display("FAIL unexpected_done dut%0d cyc=%0d want none", k, cyc);
        end else begin
          f = dq[k].pop_front();
          if (cyc !== f.cyc || cap[k] !== f.cap) begin
            bad++;
            $display("FAIL done dut%0d got cyc=%0d capture=%h want cyc=%0d capture=%h", k, cyc, cap[k], f.cyc, f.cap);
          end
        end
      end
      prev_dn[k] = dn[k];
    end
  end

  task automatic push_xfer(input int k, input logic [7:0] b, input int e0);
    for (int i = 0; i < 8; i++)
      sq[k].push_back(sx_t'{e0 + per(k) * i + su(k), 8'(8'h80 >> i), b[i]});
    dq[k].push_back(dx_t'{e0 + 8 * per(k), b});
  endtask

  // Accepts one start; returns at the negedge after E0 with e0 = cycle count of E0.
  task automatic kick(input int k, input logic [7:0] b, output int e0);
    @(negedge ff_clock);
    start_v[k] = 1'b1;
    byte_v[k]  = b;
    @(negedge ff_clock);
    start_v[k] = 1'b0;
    byte_v[k]  = ~b;
    e0 = cyc;
    push_xfer(k, b, e0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge ff_clock);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rdy[k] !== 1'b1 || bsy[k] !== 1'b0 || strb[k] !== 8'h00 || dout[k] !== 1'b0 || dn[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset dut%0d got ready=%b busy=%b strobe=%h data=%b done=%b want 1 0 00 0 0",
                 k, rdy[k], bsy[k], strb[k], dout[k], dn[k]);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge ff_clock);
  endtask

  task automatic test_serialise(input int k, input logic [7:0] b);
    int e0;
    int n;
    kick(k, b, e0);
    total++;
    if (rdy[k] !== 1'b0 || bsy[k] !== 1'b1 || dout[k] !== b[0]) begin
      bad++;
      $display("FAIL accept dut%0d byte=%h got ready=%b busy=%b data=%b want 0 1 %b", k, b, rdy[k], bsy[k], dout[k], b[0]);
    end
    for (n = 0; n < 200 && dq[k].size() != 0; n++) @(negedge ff_clock);
    total++;
    if (dq[k].size() != 0 || sq[k].size() != 0) begin
      bad++;
      $display("FAIL drain dut%0d byte=%h got pending strobes=%0d dones=%0d want 0 0", k, b, sq[k].size(), dq[k].size());
      sq[k].delete();
      dq[k].delete();
    end
    @(negedge ff_clock);
    total++;
    if (rdy[k] !== 1'b1 || bsy[k] !== 1'b0 || strb[k] !== 8'h00 || dn[k] !== 1'b0) begin
      bad++;
      $display("FAIL idle_after dut%0d byte=%h got ready=%b busy=%b strobe=%h done=%b want 1 0 00 0",
               k, b, rdy[k], bsy[k], strb[k], dn[k]);
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    int n;
    @(negedge ff_clock);
    start_v[0] = 1'b1;
    byte_v[0]  = 8'h01;
    @(negedge ff_clock);
    e0 = cyc;
    push_xfer(0, 8'h01, e0);
    byte_v[0] = 8'h80;
    for (n = 0; n < 200 && cyc < e0 + 8 * per(0) + 1; n++) begin
      total++;
      if (rdy[0] !== 1'b0 || bsy[0] !== (cyc < e0 + 8 * per(0))) begin
        bad++;
        $display("FAIL b2b_busy cyc=%0d got ready=%b busy=%b want 0 %b", cyc, rdy[0], bsy[0], cyc < e0 + 8 * per(0));
      end
      @(negedge ff_clock);
    end
    total++;
    if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ready cyc=%0d got ready=%b busy=%b want 1 0", cyc, rdy[0], bsy[0]);
    end
    @(negedge ff_clock);
    e0 = cyc;
    start_v[0] = 1'b0;
    push_xfer(0, 8'h80, e0);
    byte_v[0] = 8'h00;
    total++;
    if (rdy[0] !== 1'b0 || bsy[0] !== 1'b1 || dout[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second cyc=%0d got ready=%b busy=%b data=%b want 0 1 0", cyc, rdy[0], bsy[0], dout[0]);
    end
    for (n = 0; n < 200 && dq[0].size() != 0; n++) @(negedge ff_clock);
    total++;
    if (dq[0].size() != 0 || sq[0].size() != 0) begin
      bad++;
      $display("FAIL b2b_drain got pending strobes=%0d dones=%0d want 0 0", sq[0].size(), dq[0].size());
      sq[0].delete();
      dq[0].delete();
    end
    repeat (2) @(negedge ff_clock);
  endtask

  task automatic test_reset_abort();
    int e0;
    int n;
    kick(0, 8'h5A, e0);
    for (n = 0; n < 200 && cyc < e0 + per(0) * 3 + su(0); n++) @(negedge ff_clock);
    total++;
    if (strb[0] !== 8'h10) begin
      bad++;
      $display("FAIL abort_pre cyc=%0d got strobe=%h want 10", cyc, strb[0]);
    end
    #2 rst = 1'b1;
    #1;
    sq[0].delete();
    dq[0].delete();
    total++;
    if (strb[0] !== 8'h00 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1 || dout[0] !== 1'b0 || dn[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset got strobe=%h busy=%b ready=%b data=%b done=%b want 00 0 1 0 0",
               strb[0], bsy[0], rdy[0], dout[0], dn[0]);
    end
    @(negedge ff_clock);
    #2 rst = 1'b0;
    repeat (20) @(negedge ff_clock);
    total++;
    if (strb[0] !== 8'h00 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      bad++;
      $display("FAIL abort_quiet got strobe=%h busy=%b ready=%b want 00 0 1", strb[0], bsy[0], rdy[0]);
    end
    test_serialise(0, 8'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_serialise(0, 8'hA5);
    test_serialise(1, 8'h3C);
    test_serialise(0, 8'h81);
    test_serialise(1, 8'h81);
    test_back_to_back();
    test_reset_abort();
    repeat (4) @(negedge ff_clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_strobe_seq.md
CLK_STROBE_SEQ -- requirements
Module: clk_strobe_seq

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 1, range 1..15: cycles data_out is held stable before each strobe rises.
REQ-002 SHALL have port ff_clock, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1, request to serialise byte_in.
REQ-005 SHALL have port byte_in, input, 8, byte to deliver; sampled only when a start is accepted.
REQ-006 SHALL have port ready, output, 1, high when a start will be accepted.
REQ-007 SHALL have port data_out, output, 1, serial bit; drives the capture bank's shared data input.
REQ-008 SHALL have port strobe, output, 8, per-bit capture clocks; drives the capture bank's clock bus (strobe[7] loads bank bit 0 ... strobe[0] loads bank bit 7).
REQ-009 SHALL have port busy, output, 1, high from start acceptance until done is asserted.
REQ-010 SHALL have port done, output, 1, single-cycle pulse after the last strobe falls.

Function
REQ-011 SHALL drive all outputs directly from flip-flops, so strobe lines are glitch-free.
REQ-012 SHALL implement FSM states IDLE, SETUP, STROBE, (HOLD), DONE.
REQ-013 IDLE: ready=1, busy=0, strobe=0; start=1 at edge E0 SHALL latch byte_in, set bit index i=0, and enter SETUP with data_out=byte_in[0].
REQ-014 SETUP SHALL last SETUP_CYCLES cycles, with strobe=0 and data_out=latched bit i; it then enters STROBE.
REQ-015 STROBE SHALL last exactly 1 cycle with only strobe[7-i]=1 (one-hot), and data_out unchanged.
REQ-016 After STROBE: if i<7, the FSM SHALL increment i, clear the strobe, and enter SETUP with data_out=bit i+1; if i=7, it SHALL clear the strobe and enter DONE.
REQ-017 With SETUP_CYCLES=1: strobe[7-i] SHALL be high after edge E(2i+1) only, and done SHALL be high after E16 for one cycle; the FSM returns to IDLE after E17.
REQ-018 Bit order SHALL be byte_in[0] first, so the downstream 8-bit capture equals byte_in after done.
REQ-019 start while busy SHALL be ignored; byte_in changes after acceptance SHALL have no effect.
REQ-020 At most one strobe bit SHALL be high in any cycle; strobe and data_out SHALL never change on the same edge in the same bit slot, except the data_out update on the edge where the strobe falls.
REQ-021 ready SHALL be 0 from E0 until the FSM re-enters IDLE; start coincident with the DONE cycle SHALL be ignored.

Reset
REQ-022 rst=1 SHALL immediately force state=IDLE, strobe=8'h00, data_out=0, done=0, busy=0, ready=1, i=0, and latched byte=0.
REQ-023 rst mid-transfer SHALL abort without any further strobe edge; after release, the first accepted start SHALL begin a fresh transfer at bit 0.
REQ-024 Release of rst SHALL be the only requirement; no synchronous clear is provided.

Configuration
REQ-025 Macro STROBE_HOLD_EN defined: a 1-cycle HOLD state SHALL follow every STROBE, with strobe=0 and data_out unchanged, before the next SETUP or DONE; each bit takes SETUP_CYCLES+2 cycles, and done is high after E24 for the default setting.
REQ-026 Macro STROBE_HOLD_EN undefined: no HOLD state SHALL exist, and the timing is as per REQ-017.

Verification
REQ-027 Reset, then start with byte_in=8'hA5 -> strobe pulses 8'h80,8'h40,...,8'h01 after E1,E3,...,E15; data_out sequence 1,0,1,0,0,1,0,1; done after E16; a model capture bank reads 8'hA5.
REQ-028 byte_in=8'h3C, SETUP_CYCLES=3 -> each strobe is preceded by 3 cycles of stable data_out; done after E32.
REQ-029 Assert rst for 1 cycle after the strobe for bit 3 -> strobe=0 and busy=0 immediately, with no further strobes; a new start with 8'hFF then completes normally with capture 8'hFF.
REQ-030 Pulse start every cycle during a transfer of 8'h01 -> only one transfer runs; the second start is accepted only after ready returns high.
REQ-031 STROBE_HOLD_EN defined, byte_in=8'h81 -> strobes after E1,E4,...,E22; done after E24; capture 8'h81.
REQ-032 All runs -> assert that strobe is zero or one-hot in every cycle, and that done is a single-cycle pulse.
